// File: rtl/paddle_motion_ctrl.sv
// Rate-limited paddle mover: accelerates through a table of speed levels while a
// direction (manual buttons or AI target row) stays valid, and clamps to the screen.
module paddle_motion_ctrl #(
  parameter int V_VIDEO     = 480,
  parameter int PDL_HEIGHT  = 96,
  parameter int START_X     = 24,
  parameter int CLK_HZ      = 25_175_000,
  parameter int MIN_SPEED   = 300,
  parameter int SPEED_INC   = 200,
  parameter int ACCEL_STEPS = 4,
  parameter int STEP_PIXELS = 16,
  parameter int AI_DEADBAND = 2
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       reset_game,
  input  logic [1:0] mode,
  input  logic       move_up,
  input  logic       move_down,
  input  logic [9:0] ai_target,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] speed_lvl,
  output logic       moving,
  output logic       at_top,
  output logic       at_bottom
);

  localparam int         Y_MAX_I = V_VIDEO - PDL_HEIGHT;
  localparam logic [9:0] Y_MAX   = 10'(Y_MAX_I);
  localparam logic [9:0] CENTRE  = 10'(Y_MAX_I / 2);
  localparam int         PIX_W   = $clog2(STEP_PIXELS + 1);
  localparam logic [2:0] LVL_TOP = 3'(ACCEL_STEPS - 1);

  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} dir_t;
  typedef enum logic       {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Cycles per pixel at speed level k; evaluated only with constant arguments.
  function automatic logic [19:0] per_fn(input int k);
    per_fn = 20'(CLK_HZ / (MIN_SPEED + k * SPEED_INC));
  endfunction

  state_t           state_r;
  dir_t             run_dir_r;
  logic [1:0]       mode_r;
  logic [9:0]       y_r;
  logic [2:0]       lvl_r;
  logic [19:0]      presc_r;
  logic [PIX_W-1:0] pix_r;
  logic             moving_r;
  logic             at_top_r;
  logic             at_bottom_r;

  dir_t             dir_s;
  logic [9:0]       tgt_s;
  logic             go_s;
  logic [19:0]      per_s;
  logic [9:0]       y_step_s;
  logic             lands_s;
  logic [PIX_W-1:0] pix_inc_s;

  assign x_pos     = 10'(START_X);
  assign y_pos     = y_r;
  assign speed_lvl = lvl_r;
  assign moving    = moving_r;
  assign at_top    = at_top_r;
  assign at_bottom = at_bottom_r;

  // AI target clamped into the reachable range.
  always_comb begin
    tgt_s = ai_target;
    if (ai_target > Y_MAX) begin
      tgt_s = Y_MAX;
    end else begin
      tgt_s = ai_target;
    end
  end

  // Requested direction for this cycle; 11-bit compares avoid wrap near the top of range.
  always_comb begin
    dir_s = DIR_NONE;
    case (mode)
      2'b10: begin
        if (move_up && !move_down) begin
          dir_s = DIR_UP;
        end else if (move_down && !move_up) begin
          dir_s = DIR_DOWN;
        end else begin
          dir_s = DIR_NONE;
        end
      end
      2'b01: begin
        if ({1'b0, y_r} > ({1'b0, tgt_s} + 11'(AI_DEADBAND))) begin
          dir_s = DIR_UP;
        end else if ({1'b0, tgt_s} > ({1'b0, y_r} + 11'(AI_DEADBAND))) begin
          dir_s = DIR_DOWN;
        end else begin
          dir_s = DIR_NONE;
        end
      end
      default: dir_s = DIR_NONE;
    endcase
  end

  // A direction is actionable only if the paddle is not already pinned against that limit.
  always_comb begin
    go_s = 1'b0;
    if (dir_s == DIR_UP) begin
      go_s = (y_r != 10'd0);
    end else if (dir_s == DIR_DOWN) begin
      go_s = (y_r != Y_MAX);
    end else begin
      go_s = 1'b0;
    end
  end

  // Period for the current speed level.
  always_comb begin
    per_s = per_fn(0);
    case (lvl_r)
      3'd0:    per_s = per_fn(0);
      3'd1:    per_s = per_fn(1);
      3'd2:    per_s = per_fn(2);
      3'd3:    per_s = per_fn(3);
      3'd4:    per_s = per_fn(4);
      3'd5:    per_s = per_fn(5);
      3'd6:    per_s = per_fn(6);
      3'd7:    per_s = per_fn(7);
      default: per_s = per_fn(0);
    endcase
  end

  // Candidate position after one step in the travel direction and whether it hits a limit.
  always_comb begin
    y_step_s  = y_r;
    lands_s   = 1'b0;
    pix_inc_s = pix_r + {{(PIX_W-1){1'b0}}, 1'b1};
    if (run_dir_r == DIR_UP) begin
      y_step_s = y_r - 10'd1;
      lands_s  = (y_step_s == 10'd0);
    end else begin
      y_step_s = y_r + 10'd1;
      lands_s  = (y_step_s == Y_MAX);
    end
  end

  // Motion FSM with registered position, speed level and status flags.
  always_ff @(posedge clk_0) begin
    if (!rst || reset_game) begin
      state_r     <= ST_IDLE;
      run_dir_r   <= DIR_NONE;
      mode_r      <= mode;
      y_r         <= CENTRE;
      lvl_r       <= 3'd0;
      presc_r     <= 20'd0;
      pix_r       <= '0;
      moving_r    <= 1'b0;
      at_top_r    <= (CENTRE == 10'd0);
      at_bottom_r <= (CENTRE == Y_MAX);
    end else begin
      mode_r <= mode;
      if (mode != mode_r) begin
        // A mode switch always restarts from rest so the new source begins at level 0.
        state_r  <= ST_IDLE;
        lvl_r    <= 3'd0;
        presc_r  <= 20'd0;
        pix_r    <= '0;
        moving_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (go_s) begin
              // The entry edge already counts as prescaler tick 0.
              state_r   <= ST_RUN;
              run_dir_r <= dir_s;
              presc_r   <= 20'd1;
              moving_r  <= 1'b1;
            end else begin
              lvl_r    <= 3'd0;
              presc_r  <= 20'd0;
              pix_r    <= '0;
              moving_r <= 1'b0;
            end
          end
          ST_RUN: begin
            if (!go_s) begin
              state_r  <= ST_IDLE;
              lvl_r    <= 3'd0;
              presc_r  <= 20'd0;
              pix_r    <= '0;
              moving_r <= 1'b0;
            end else if (dir_s != run_dir_r) begin
              run_dir_r <= dir_s;
              lvl_r     <= 3'd0;
              presc_r   <= 20'd0;
              pix_r     <= '0;
              moving_r  <= 1'b1;
            end else if (presc_r == (per_s - 20'd1)) begin
              y_r         <= y_step_s;
              presc_r     <= 20'd0;
              at_top_r    <= (y_step_s == 10'd0);
              at_bottom_r <= (y_step_s == Y_MAX);
              if (lands_s) begin
                state_r  <= ST_IDLE;
                lvl_r    <= 3'd0;
                pix_r    <= '0;
                moving_r <= 1'b0;
              end else if (pix_inc_s == PIX_W'(STEP_PIXELS)) begin
                pix_r    <= '0;
                moving_r <= 1'b1;
                if (lvl_r < LVL_TOP) begin
                  lvl_r <= lvl_r + 3'd1;
                end else begin
                  lvl_r <= lvl_r;
                end
              end else begin
                pix_r    <= pix_inc_s;
                moving_r <= 1'b1;
              end
            end else begin
              presc_r  <= presc_r + 20'd1;
              moving_r <= 1'b1;
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            lvl_r    <= 3'd0;
            presc_r  <= 20'd0;
            pix_r    <= '0;
            moving_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
